// File: rtl/ball_serve_if.sv
// Serve handshake bundle between ball_serve (master) and the ball-motion block (slave).
interface ball_serve_if #(
    parameter int unsigned SPEED_W = 4
);
    logic               serve_valid_o;
    logic               serve_ready_i;
    logic               serve_dir_o;
    logic [SPEED_W-1:0] serve_dy_o;

    modport master (output serve_valid_o, output serve_dir_o, output serve_dy_o, input serve_ready_i);
    modport slave  (input serve_valid_o, input serve_dir_o, input serve_dy_o, output serve_ready_i);
endinterface

// File: rtl/ball_serve.sv
// Serve controller: random pre-serve pause, then offers (dir, signed dy) over valid/ready.
// Optional BALL_SERVE_COUNT_EN adds serve_cnt_o, a wrapping count of completed serves.
module ball_serve #(
    parameter int unsigned RND_W      = 16,
    parameter int unsigned MIN_FRAMES = 30,
    parameter int unsigned DLY_BITS   = 5,
    parameter int unsigned SPD_BITS   = 2,
    parameter int unsigned SPEED_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [RND_W-1:0] rnd_num_i,
    input  logic             frame_tick_i,
    input  logic             start_i,
    input  logic             score_l_i,
    input  logic             score_r_i,
    ball_serve_if.master     srv,
    output logic             busy_o
`ifdef BALL_SERVE_COUNT_EN
    ,
    output logic [7:0]       serve_cnt_o
`endif
);
    localparam int unsigned CNT_W = $clog2(MIN_FRAMES + 2**DLY_BITS);

    if (SPEED_W < SPD_BITS + 2) begin : g_bad_speed_w
        $error("SPEED_W cannot hold +/-2**SPD_BITS");
    end
    if (DLY_BITS + SPD_BITS > RND_W - 1) begin : g_bad_rnd_w
        $error("RND_W too narrow for delay, speed and sign fields");
    end
    if (MIN_FRAMES < 1) begin : g_bad_min
        $error("MIN_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OFFER} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir_pend;
    logic               r_valid;
    logic               r_dir;
    logic [SPEED_W-1:0] r_dy;
    logic               r_busy;
`ifdef BALL_SERVE_COUNT_EN
    logic [7:0]         r_serve_cnt;
`endif

    logic               w_event;
    logic               w_ev_dir;
    logic [CNT_W-1:0]   w_load;
    logic [SPEED_W-1:0] w_mag;
    logic [SPEED_W-1:0] w_dy;
    logic               w_unused_rnd;

    assign w_event  = score_l_i | score_r_i | start_i;
    assign w_ev_dir = score_l_i ? 1'b1 : (score_r_i ? 1'b0 : rnd_num_i[0]);
    assign w_load   = CNT_W'(MIN_FRAMES) + CNT_W'(rnd_num_i[DLY_BITS-1:0]);
    assign w_mag    = SPEED_W'(rnd_num_i[DLY_BITS +: SPD_BITS]) + SPEED_W'(1);
    assign w_dy     = rnd_num_i[RND_W-1] ? (~w_mag + SPEED_W'(1)) : w_mag;
    assign w_unused_rnd = ^rnd_num_i;

    // Direction is held privately until OFFER so the outputs stay at the last serve's values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dir_pend  <= 1'b0;
            r_valid     <= 1'b0;
            r_dir       <= 1'b0;
            r_dy        <= '0;
            r_busy      <= 1'b0;
`ifdef BALL_SERVE_COUNT_EN
            r_serve_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_dir_pend <= w_ev_dir;
                        r_cnt      <= w_load;
                        r_state    <= S_WAIT;
                        r_busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_tick_i) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_OFFER;
                            r_valid <= 1'b1;
                            r_dir   <= r_dir_pend;
                            r_dy    <= w_dy;
                        end
                    end
                end
                S_OFFER: begin
                    if (srv.serve_ready_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
`ifdef BALL_SERVE_COUNT_EN
                        r_serve_cnt <= r_serve_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign srv.serve_valid_o = r_valid;
    assign srv.serve_dir_o   = r_dir;
    assign srv.serve_dy_o    = r_dy;
    assign busy_o            = r_busy;
`ifdef BALL_SERVE_COUNT_EN
    assign serve_cnt_o       = r_serve_cnt;
`endif
endmodule

// File: tb/tb_ball_serve.sv
// Self-checking bench for ball_serve: directed and randomized serves against an arithmetic model.
module tb_ball_serve;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] rnd_num_i;
    logic        frame_tick_i;
    logic        start_i;
    logic        score_l_i;
    logic        score_r_i;
    logic        busy_o;
`ifdef BALL_SERVE_COUNT_EN
    logic [7:0]  serve_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    // Model of what the outputs should hold between serves
    logic       m_dir;
    logic [3:0] m_dy;
    int         m_served;

    ball_serve_if #(.SPEED_W(4)) bus ();

    ball_serve #(
        .RND_W(16), .MIN_FRAMES(30), .DLY_BITS(5), .SPD_BITS(2), .SPEED_W(4)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rnd_num_i    (rnd_num_i),
        .frame_tick_i (frame_tick_i),
        .start_i      (start_i),
        .score_l_i    (score_l_i),
        .score_r_i    (score_r_i),
        .srv          (bus),
        .busy_o       (busy_o)
`ifdef BALL_SERVE_COUNT_EN
        ,
        .serve_cnt_o  (serve_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dy_model(input logic [15:0] r);
        int mag;
        int v;
        mag = 1 + ((int'(r) >> 5) & 3);
        v   = r[15] ? -mag : mag;
        return 4'(v);
    endfunction

    task automatic noise_pulses();
        rnd_num_i    = 16'($urandom);
        score_l_i    = ($urandom_range(0, 3) == 0);
        score_r_i    = ($urandom_range(0, 2) == 0);
        start_i      = ($urandom_range(0, 3) == 0);
        frame_tick_i = 1'b0;
    endtask

    task automatic clear_pulses();
        score_l_i = 1'b0; score_r_i = 1'b0; start_i = 1'b0; frame_tick_i = 1'b0;
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_dir"}, 32'(bus.serve_dir_o), 32'(m_dir));
        chk({tag, "_dy"},  32'(bus.serve_dy_o),  32'(m_dy));
    endtask

    // ev: 0=L 1=R 2=start 3=L+start 4=R+start
    task automatic do_serve(input int ev, input logic [15:0] rnd_ev, input logic [15:0] rnd_tr,
                            input int hold, input int max_gap, input bit early_rdy, input bit noise);
        int         d;
        int         gap;
        logic       edir;
        logic [3:0] edy;
        d    = 30 + int'(rnd_ev[4:0]);
        edir = (ev == 1 || ev == 4) ? 1'b0 : (ev == 2) ? rnd_ev[0] : 1'b1;
        edy  = dy_model(rnd_tr);

        rnd_num_i = rnd_ev;
        score_l_i = (ev == 0 || ev == 3);
        score_r_i = (ev == 1 || ev == 4);
        start_i   = (ev >= 2);
        bus.serve_ready_i = early_rdy;
        step();
        clear_pulses();
        chk("wait_busy", 32'(busy_o), 32'd1);
        chk("wait_valid", 32'(bus.serve_valid_o), 32'd0);
        chk_held("wait_hold");

        for (int t = 1; t <= d; t++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                if (noise) noise_pulses(); else rnd_num_i = 16'($urandom);
                step();
                clear_pulses();
            end
            rnd_num_i    = (t == d) ? rnd_tr : 16'($urandom);
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            if (t < d) chk("valid_early", 32'(bus.serve_valid_o), 32'd0);
        end

        chk("offer_valid", 32'(bus.serve_valid_o), 32'd1);
        chk("offer_busy", 32'(busy_o), 32'd1);
        m_dir = edir;
        m_dy  = edy;
        chk_held("offer");

        if (!early_rdy) begin
            for (int h = 0; h < hold; h++) begin
                if (noise) begin
                    noise_pulses();
                    frame_tick_i = $urandom_range(0, 1) == 1;
                end
                step();
                clear_pulses();
                chk("hold_valid", 32'(bus.serve_valid_o), 32'd1);
                chk_held("hold");
            end
            bus.serve_ready_i = 1'b1;
        end
        step();
        bus.serve_ready_i = 1'b0;
        m_served++;
        chk("done_valid", 32'(bus.serve_valid_o), 32'd0);
        chk("done_busy", 32'(busy_o), 32'd0);
        chk_held("done");
`ifdef BALL_SERVE_COUNT_EN
        chk("serve_cnt", 32'(serve_cnt_o), 32'(m_served % 256));
`endif
    endtask

    initial begin
        rst_n_i = 1'b0;
        rnd_num_i = 16'h0;
        clear_pulses();
        bus.serve_ready_i = 1'b0;
        m_dir = 1'b0; m_dy = 4'h0; m_served = 0;

        repeat (3) step();
        chk("rst_valid", 32'(bus.serve_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n_i = 1'b1;
        step();
        chk("rel_valid", 32'(bus.serve_valid_o), 32'd0);
        chk("rel_busy", 32'(busy_o), 32'd0);
        chk_held("rel");

        // Directed serves from the test plan
        do_serve(0, 16'h0003, 16'h0020, 2, 0, 1'b0, 1'b0);
        do_serve(1, 16'h001F, 16'h8060, 1, 0, 1'b0, 1'b0);
        do_serve(2, 16'h0001, 16'h1234, 5, 0, 1'b0, 1'b0);
        do_serve(3, 16'h0000, 16'h0040, 0, 0, 1'b0, 1'b0);
        do_serve(4, 16'h0011, 16'hFFFF, 3, 3, 1'b0, 1'b1);
        do_serve(1, 16'h0007, 16'h8000, 4, 2, 1'b0, 1'b1);
        do_serve(2, 16'h0010, 16'h0060, 0, 1, 1'b1, 1'b0);

        // Ticks while idle must not start anything
        repeat (4) begin
            frame_tick_i = 1'b1;
            step();
            chk("idle_tick_busy", 32'(busy_o), 32'd0);
        end
        frame_tick_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_serve(int'($urandom_range(0, 4)), 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                     $urandom_range(0, 3) == 0, 1'b1);
        end

        // Asynchronous reset in the middle of WAIT
        rnd_num_i = 16'h0000;
        score_l_i = 1'b1;
        step();
        clear_pulses();
        repeat (5) begin
            frame_tick_i = 1'b1;
            step();
        end
        frame_tick_i = 1'b0;
        chk("midwait_busy", 32'(busy_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        m_dir = 1'b0; m_dy = 4'h0; m_served = 0;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_valid", 32'(bus.serve_valid_o), 32'd0);
        chk_held("arst");
        step();
        rst_n_i = 1'b1;
        repeat (40) begin
            frame_tick_i = 1'b1;
            step();
        end
        frame_tick_i = 1'b0;
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_valid", 32'(bus.serve_valid_o), 32'd0);
`ifdef BALL_SERVE_COUNT_EN
        chk("post_rst_cnt", 32'(serve_cnt_o), 32'd0);
        for (int i = 0; i < 255; i++) begin
            do_serve(int'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);
        end
        chk("cnt_255", 32'(serve_cnt_o), 32'd255);
        do_serve(0, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0);
        chk("cnt_wrap", 32'(serve_cnt_o), 32'd0);
`endif
        do_serve(0, 16'h0000, 16'h0000, 1, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
